dmac_evt_buffer: RTL and testbench

DMAC_EVT_BUFFER -- requirements
Module: dmac_evt_buffer

---
 rtl/dmac_evt_buffer.sv | 83 ++++++++
 tb/tb_dmac_evt_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmac_evt_buffer.sv
// Per-target DMA termination event buffer: saturating pending-event counters
// with valid/ready drain, sticky overflow, registered irq pulses and idle flag.
module dmac_evt_buffer #(
  parameter int NB_CORES  = 8,
  parameter int CNT_WIDTH = 3,
  localparam int NB_TGT   = NB_CORES + 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NB_TGT-1:0] term_evt_i,
  input  logic [NB_TGT-1:0] term_irq_i,
  input  logic              dma_busy_i,
  output logic [NB_TGT-1:0] evt_valid_o,
  input  logic [NB_TGT-1:0] evt_ready_i,
  output logic [NB_TGT-1:0] irq_o,
  output logic [NB_TGT-1:0] ovf_o,
  input  logic [NB_TGT-1:0] clr_i,
  output logic              idle_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [NB_TGT-1:0][CNT_WIDTH-1:0] r_cnt;
  logic [NB_TGT-1:0][CNT_WIDTH-1:0] w_cnt_nxt;
  logic [NB_TGT-1:0]                r_ovf;
  logic [NB_TGT-1:0]                w_ovf_nxt;
  logic [NB_TGT-1:0]                r_irq;
  logic [NB_TGT-1:0]                w_hs;
  logic                             r_idle;
  logic                             w_all_zero;

  // Handshake: per target, an event transfers on a cycle where evt_valid_o[t]
  // and evt_ready_i[t] are both high; valid depends only on the counter
  // register and never on ready, and it stays high until the transfer.
  always_comb begin
    evt_valid_o = '0;
    w_all_zero  = 1'b1;
    for (int t = 0; t < NB_TGT; t++) begin
      evt_valid_o[t] = (r_cnt[t] != '0);
      if (r_cnt[t] != '0) w_all_zero = 1'b0;
    end
  end

  assign w_hs = evt_valid_o & evt_ready_i;

  // Clear wins over everything; a pulse at the saturated value is dropped
  // and recorded in the sticky overflow flag.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    for (int t = 0; t < NB_TGT; t++) begin
      if (clr_i[t]) begin
        w_cnt_nxt[t] = '0;
        w_ovf_nxt[t] = 1'b0;
      end else if (term_evt_i[t] && !w_hs[t]) begin
        if (r_cnt[t] == CNT_MAX) w_ovf_nxt[t] = 1'b1;
        else                     w_cnt_nxt[t] = r_cnt[t] + CNT_ONE;
      end else if (w_hs[t] && !term_evt_i[t]) begin
        w_cnt_nxt[t] = r_cnt[t] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_ovf  <= '0;
      r_irq  <= '0;
      r_idle <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_ovf  <= w_ovf_nxt;
      r_irq  <= term_irq_i;
      r_idle <= !dma_busy_i && w_all_zero;
    end
  end

  assign irq_o  = r_irq;
  assign ovf_o  = r_ovf;
  assign idle_o = r_idle;

endmodule

// File: tb/tb_dmac_evt_buffer.sv
// Bench for dmac_evt_buffer: directed vector table, hand-written corner
// sequences and randomized traffic against a counting reference model.
module tb_dmac_evt_buffer;

  localparam int N     = 10;
  localparam int CNT_W = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] term_evt, term_irq, evt_ready, clr;
  logic         dma_busy;
  logic [N-1:0] evt_valid, irq, ovf;
  logic         idle;

  int n_checks = 0;
  int n_errs   = 0;

  dmac_evt_buffer #(.NB_CORES(8), .CNT_WIDTH(CNT_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .term_evt_i (term_evt),
    .term_irq_i (term_irq),
    .dma_busy_i (dma_busy),
    .evt_valid_o(evt_valid),
    .evt_ready_i(evt_ready),
    .irq_o      (irq),
    .ovf_o      (ovf),
    .clr_i      (clr),
    .idle_o     (idle)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string        name;
    logic [N-1:0] evt, irq_in, rdy, clr;
    logic         busy;
    logic [N-1:0] x_valid, x_ovf, x_irq;
    logic         x_idle;
  } vec_t;

  vec_t         tbl[$];
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [N-1:0] v, input logic [N-1:0] o,
                         input logic [N-1:0] i, input logic d);
    chk({name, ".valid"}, 32'(evt_valid), 32'(v));
    chk({name, ".ovf"},   32'(ovf),       32'(o));
    chk({name, ".irq"},   32'(irq),       32'(i));
    chk({name, ".idle"},  32'(idle),      32'(d));
  endtask

  // driver: apply inputs at a falling edge, return at the next falling edge
  task automatic drive(input logic [N-1:0] e, input logic [N-1:0] q, input logic [N-1:0] r,
                       input logic [N-1:0] c, input logic b);
    term_evt  = e;
    term_irq  = q;
    evt_ready = r;
    clr       = c;
    dma_busy  = b;
    @(negedge clk);
  endtask

  task automatic add(input string nm, input logic [N-1:0] e, input logic [N-1:0] q,
                     input logic [N-1:0] r, input logic [N-1:0] c, input logic b,
                     input logic [N-1:0] xv, input logic [N-1:0] xo,
                     input logic [N-1:0] xi, input logic xd);
    vec_t v;
    v.name = nm; v.evt = e; v.irq_in = q; v.rdy = r; v.clr = c; v.busy = b;
    v.x_valid = xv; v.x_ovf = xo; v.x_irq = xi; v.x_idle = xd;
    tbl.push_back(v);
  endtask

  // reference model state
  int           m_cnt[N];
  logic [N-1:0] m_ovf;

  initial begin
    logic [N-1:0] e, q, r, c, xv;
    logic         b, xd;
    int           p_evt, p_rdy, nv, tot;

    // table: {inputs} -> {outputs after the next rising edge}
    add("busy0",      10'h000, 10'h000, 10'h000, 10'h000, 1, 10'h000, 10'h000, 10'h000, 0);
    add("evt2",       10'h004, 10'h000, 10'h000, 10'h000, 1, 10'h004, 10'h000, 10'h000, 0);
    add("hold2a",     10'h000, 10'h000, 10'h000, 10'h000, 1, 10'h004, 10'h000, 10'h000, 0);
    add("rdy_noval",  10'h000, 10'h000, 10'h008, 10'h000, 1, 10'h004, 10'h000, 10'h000, 0);
    add("hold2b",     10'h000, 10'h000, 10'h000, 10'h000, 1, 10'h004, 10'h000, 10'h000, 0);
    add("hold2c",     10'h000, 10'h000, 10'h000, 10'h000, 1, 10'h004, 10'h000, 10'h000, 0);
    add("hs2",        10'h000, 10'h000, 10'h004, 10'h000, 1, 10'h000, 10'h000, 10'h000, 0);
    add("evt9",       10'h200, 10'h000, 10'h000, 10'h000, 1, 10'h200, 10'h000, 10'h000, 0);
    add("simul9",     10'h200, 10'h000, 10'h200, 10'h000, 1, 10'h200, 10'h000, 10'h000, 0);
    add("drain9",     10'h000, 10'h000, 10'h200, 10'h000, 1, 10'h000, 10'h000, 10'h000, 0);
    add("evt4",       10'h010, 10'h000, 10'h000, 10'h000, 1, 10'h010, 10'h000, 10'h000, 0);
    add("clr_prio4",  10'h010, 10'h000, 10'h010, 10'h010, 1, 10'h000, 10'h000, 10'h000, 0);
    add("after_clr",  10'h000, 10'h000, 10'h000, 10'h000, 1, 10'h000, 10'h000, 10'h000, 0);
    add("irq_all",    10'h000, 10'h3FF, 10'h000, 10'h000, 1, 10'h000, 10'h000, 10'h3FF, 0);
    add("irq_once",   10'h000, 10'h000, 10'h000, 10'h000, 1, 10'h000, 10'h000, 10'h000, 0);
    add("idle_rise",  10'h000, 10'h000, 10'h000, 10'h000, 0, 10'h000, 10'h000, 10'h000, 1);
    add("idle_old",   10'h001, 10'h000, 10'h000, 10'h000, 0, 10'h001, 10'h000, 10'h000, 1);
    add("idle_pend",  10'h000, 10'h000, 10'h000, 10'h000, 0, 10'h001, 10'h000, 10'h000, 0);
    add("idle_drain", 10'h000, 10'h000, 10'h001, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0);
    add("idle_back",  10'h000, 10'h000, 10'h000, 10'h000, 0, 10'h000, 10'h000, 10'h000, 1);
    add("all_evt",    10'h3FF, 10'h000, 10'h000, 10'h000, 0, 10'h3FF, 10'h000, 10'h000, 1);
    add("all_mix",    10'h155, 10'h000, 10'h3FF, 10'h000, 0, 10'h155, 10'h000, 10'h000, 0);
    add("all_drain",  10'h000, 10'h000, 10'h3FF, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0);
    add("all_idle",   10'h000, 10'h000, 10'h000, 10'h000, 0, 10'h000, 10'h000, 10'h000, 1);

    // reset
    rst_n = 1'b0;
    term_evt = '0; term_irq = '0; evt_ready = '0; clr = '0; dma_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 10'h000, 10'h000, 10'h000, 0);
    rst_n = 1'b1;

    foreach (tbl[k])
      begin
        drive(tbl[k].evt, tbl[k].irq_in, tbl[k].rdy, tbl[k].clr, tbl[k].busy);
        chk_all(tbl[k].name, tbl[k].x_valid, tbl[k].x_ovf, tbl[k].x_irq, tbl[k].x_idle);
      end

    // saturation: 9 pulses on target 0, overflow only from the 8th
    for (int k = 1; k <= 9; k++) begin
      drive(10'h001, '0, '0, '0, 1);
      chk("sat.valid", 32'(evt_valid), 32'h001);
      chk("sat.ovf",   32'(ovf),       (k >= 8) ? 32'h001 : 32'h000);
    end
    for (int k = 1; k <= 7; k++) begin
      drive('0, '0, 10'h001, '0, 1);
      chk("drain.valid", 32'(evt_valid), (k < 7) ? 32'h001 : 32'h000);
      chk("drain.ovf",   32'(ovf),       32'h001);
    end
    drive('0, '0, 10'h001, '0, 1);
    chk("drain.extra", 32'(evt_valid), 32'h000);
    drive('0, '0, '0, 10'h001, 1);
    chk("clr.ovf", 32'(ovf), 32'h000);

    // reset mid-stream with pending events, overflow and an irq in flight
    for (int k = 0; k < 8; k++) drive(10'h0C3, (k == 7) ? 10'h0FF : 10'h000, '0, '0, 0);
    chk_all("pre_rst", 10'h0C3, 10'h0C3, 10'h0FF, 0);
    drive('0, '0, '0, '0, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("rst_async", 10'h000, 10'h000, 10'h000, 0);
    repeat (2) begin
      @(negedge clk);
      chk_all("rst_hold", 10'h000, 10'h000, 10'h000, 0);
    end
    rst_n = 1'b1;
    #1 chk_all("rst_rel", 10'h000, 10'h000, 10'h000, 0);
    @(negedge clk);
    drive('0, '0, '0, '0, 1);
    chk_all("post_busy", 10'h000, 10'h000, 10'h000, 0);
    drive('0, '0, '0, '0, 0);
    chk_all("post_idle", 10'h000, 10'h000, 10'h000, 1);

    // randomized traffic against the counting model
    foreach (m_cnt[t]) m_cnt[t] = 0;
    m_ovf = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p_evt = ((cyc / 250) % 3 == 0) ? 70 : 25;
      p_rdy = ((cyc / 250) % 3 == 0) ? 10 : 60;
      for (int t = 0; t < N; t++) begin
        e[t] = ($urandom_range(0, 99) < p_evt);
        r[t] = ($urandom_range(0, 99) < p_rdy);
        c[t] = ($urandom_range(0, 99) < 2);
        q[t] = ($urandom_range(0, 99) < 30);
      end
      b = ($urandom_range(0, 3) == 0);

      tot = 0;
      foreach (m_cnt[t]) tot += m_cnt[t];
      xd = !b && (tot == 0);
      exp_q.push_back(q);
      for (int t = 0; t < N; t++) begin
        if (c[t]) begin
          m_cnt[t] = 0;
          m_ovf[t] = 1'b0;
        end else begin
          nv = m_cnt[t] + int'(e[t]) - int'((m_cnt[t] != 0) && r[t]);
          if (nv > MAXC) begin
            nv = MAXC;
            m_ovf[t] = 1'b1;
          end
          m_cnt[t] = nv;
        end
      end
      for (int t = 0; t < N; t++) xv[t] = (m_cnt[t] != 0);

      drive(e, q, r, c, b);
      chk_all("rand", xv, m_ovf, exp_q.pop_front(), xd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
